// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALU op codes, operand selects,
// multiplier iteration count and multiplier FSM state type.
package ex_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } alu_op_e;

    localparam logic [1:0] SRCA_RS1 = 2'd0;
    localparam logic [1:0] SRCA_PC  = 2'd1;

    localparam logic [2:0] SRCB_RS2  = 3'd0;
    localparam logic [2:0] SRCB_LSJ  = 3'd1;
    localparam logic [2:0] SRCB_UI   = 3'd2;
    localparam logic [2:0] SRCB_FOUR = 3'd3;

    localparam int unsigned MUL_ITERS = 32;
    localparam int unsigned CNT_W     = $clog2(MUL_ITERS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one partial product per clock, low 32 bits
// of the product offered combinationally on the final iteration cycle.
module mul_iter
    import ex_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic        start_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

    mul_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       acc_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic [31:0]       acc_d;

    // Accumulator value after the current iteration's partial product
    always_comb begin
        acc_d = acc_q;
        if (b_q[0]) begin
            acc_d = acc_q + a_q;
        end else begin
            acc_d = acc_q;
        end
    end

    assign busy_o    = (state_q == ST_MUL);
    assign done_o    = (state_q == ST_MUL) && (cnt_q == CNT_LAST);
    assign product_o = acc_d;

    // Multiplier FSM and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= 32'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
        end else if (flush_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        acc_q   <= 32'd0;
                        cnt_q   <= '0;
                        state_q <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    acc_q <= acc_d;
                    a_q   <= {a_q[30:0], 1'b0};
                    b_q   <= {1'b0, b_q[31:1]};
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM output register: operand muxing, single-cycle ALU
// and a 32-cycle iterative multiplier that stalls upstream while busy.
module ex_mem_stage
    import ex_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        InValid,
    input  logic [31:0] InPC,
    input  logic [31:0] Inrs1val,
    input  logic [31:0] Inrs2val,
    input  logic [31:0] InLoadStoreOrjalAddress,
    input  logic [31:0] InauipcOrlui,
    input  logic [1:0]  InALUSourceA,
    input  logic [2:0]  InALUSourceB,
    input  logic [3:0]  InALUOp,
    input  logic        Flush,
    output logic [31:0] Result,
    output logic [31:0] StoreData,
    output logic        Valid,
    output logic        Busy
);

    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_s;
    logic [31:0] mul_product_s;
    logic        mul_busy_s;
    logic        mul_done_s;
    logic        accept_s;
    logic        mul_start_s;

    logic [31:0] result_d, result_q;
    logic [31:0] store_d, store_q;
    logic [31:0] rs2_lat_d, rs2_lat_q;
    logic        valid_d, valid_q;

    // Operand selection
    always_comb begin
        op_a_s = 32'd0;
        case (InALUSourceA)
            SRCA_RS1: op_a_s = Inrs1val;
            SRCA_PC:  op_a_s = InPC;
            default:  op_a_s = 32'd0;
        endcase
        op_b_s = 32'd0;
        case (InALUSourceB)
            SRCB_RS2:  op_b_s = Inrs2val;
            SRCB_LSJ:  op_b_s = InLoadStoreOrjalAddress;
            SRCB_UI:   op_b_s = InauipcOrlui;
            SRCB_FOUR: op_b_s = 32'd4;
            default:   op_b_s = 32'd0;
        endcase
    end

    // Single-cycle ALU; MUL and unused codes fall through to pass-B
    always_comb begin
        alu_s = op_b_s;
        case (InALUOp)
            OP_ADD:  alu_s = op_a_s + op_b_s;
            OP_SUB:  alu_s = op_a_s - op_b_s;
            OP_AND:  alu_s = op_a_s & op_b_s;
            OP_OR:   alu_s = op_a_s | op_b_s;
            OP_XOR:  alu_s = op_a_s ^ op_b_s;
            OP_SLL:  alu_s = op_a_s << op_b_s[4:0];
            OP_SRL:  alu_s = op_a_s >> op_b_s[4:0];
            OP_SRA:  alu_s = 32'($signed(op_a_s) >>> op_b_s[4:0]);
            OP_SLT:  alu_s = {31'd0, $signed(op_a_s) < $signed(op_b_s)};
            OP_SLTU: alu_s = {31'd0, op_a_s < op_b_s};
            default: alu_s = op_b_s;
        endcase
    end

    assign accept_s    = InValid && !mul_busy_s && !Flush;
    assign mul_start_s = accept_s && (InALUOp == OP_MUL);

    mul_iter u_mul_iter (
        .clk_i     (CLK),
        .rst_i     (RST),
        .flush_i   (Flush),
        .start_i   (mul_start_s),
        .a_i       (op_a_s),
        .b_i       (op_b_s),
        .busy_o    (mul_busy_s),
        .done_o    (mul_done_s),
        .product_o (mul_product_s)
    );

    // Next-state for the EX/MEM register; flush wins, completion and accept never overlap
    always_comb begin
        result_d  = result_q;
        store_d   = store_q;
        rs2_lat_d = rs2_lat_q;
        valid_d   = 1'b0;
        if (Flush) begin
            valid_d = 1'b0;
        end else if (mul_done_s) begin
            result_d = mul_product_s;
            store_d  = rs2_lat_q;
            valid_d  = 1'b1;
        end else if (mul_start_s) begin
            rs2_lat_d = Inrs2val;
        end else if (accept_s) begin
            result_d = alu_s;
            store_d  = Inrs2val;
            valid_d  = 1'b1;
        end else begin
            valid_d = 1'b0;
        end
    end

    // EX/MEM output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            result_q  <= 32'd0;
            store_q   <= 32'd0;
            rs2_lat_q <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            result_q  <= result_d;
            store_q   <= store_d;
            rs2_lat_q <= rs2_lat_d;
            valid_q   <= valid_d;
        end
    end

    assign Result    = result_q;
    assign StoreData = store_q;
    assign Valid     = valid_q;
    assign Busy      = mul_busy_s;

endmodule
